// File: rtl/ram_flex_stream.sv
// Streaming single-clock RAM assembled from 2^BITS_AU x BITS_DU BRAM units, with a
// valid/ready read-request channel and a backpressured, in-order response FIFO.
module ram_flex_stream #(
   parameter int BITS_AU    = 10,
   parameter int BITS_DU    = 18,
   parameter int DEPTH      = 4096,
   parameter int BITS_D     = 16,
   parameter int INIT_COUNT = DEPTH,
   parameter logic [((BITS_D < 1) ? 1 : BITS_D)-1:0] INIT_ARRAY [INIT_COUNT] = '{default: '1},
   parameter int OUT_REG    = 0,
   parameter int RDW_MODE   = 0,
   localparam int DEPTH_E   = (DEPTH < 2) ? 2 : DEPTH,
   localparam int BITS_DE   = (BITS_D < 1) ? 1 : BITS_D,
   localparam int BITS_A    = $clog2(DEPTH_E),
   localparam int LAT       = 1 + ((OUT_REG != 0) ? 1 : 0),
   localparam int BITS_O    = $clog2(LAT + 2)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               wr_en,
   input  logic [BITS_A-1:0]  wr_addr,
   input  logic [BITS_DE-1:0] wr_data,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [BITS_A-1:0]  req_addr,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [BITS_DE-1:0] rsp_data,
   output logic [BITS_O-1:0]  outstanding
);
   localparam int UNIT_D  = 2 ** BITS_AU;
   localparam int NB      = (DEPTH_E + UNIT_D - 1) / UNIT_D;
   localparam int NS      = BITS_DE / BITS_DU;
   localparam int RW      = BITS_DE % BITS_DU;
   localparam int RW1     = (RW > 0) ? RW : 1;
   localparam int NF      = BITS_DU / RW1;
   localparam int NRB     = (RW > 0) ? (NB + NF - 1) / NF : 0;
   localparam int NS1     = (NS > 0) ? NS : 1;
   localparam int NR1     = (NRB > 0) ? NRB : 1;
   localparam int WIDE    = NS * BITS_DU + RW1;
   localparam int DEPTH_F = LAT + 1;
   localparam int BITS_P  = $clog2(DEPTH_F);
   localparam logic [BITS_O-1:0] CNT_MAX  = BITS_O'(DEPTH_F);
   localparam logic [BITS_P-1:0] PTR_LAST = BITS_P'(DEPTH_F - 1);

   typedef logic [BITS_DU-1:0] unit_t [UNIT_D];

   // Power-up image of one unit: `lanes` consecutive blocks, bits [lo +: w] of each word.
   function automatic unit_t init_unit(input int first_blk, input int lanes, input int lo, input int w);
      unit_t u;
      logic [BITS_DE-1:0] word;
      int idx;
      for (int a = 0; a < UNIT_D; a++) begin
         u[a] = '0;
         for (int f = 0; f < lanes; f++) begin
            idx  = (first_blk + f) * UNIT_D + a;
            word = (idx < DEPTH_E) ? INIT_ARRAY[idx % INIT_COUNT] : '0;
            for (int b = 0; b < w; b++) u[a][f * w + b] = word[lo + b];
         end
      end
      return u;
   endfunction

   logic wr_ok, acc, hs, push, pop, fifo_empty, last_v, rd_in_range, run_q;
   int wr_blk, rd_blk, rblk_q;
   logic [BITS_AU-1:0] wr_off, rd_off;
   logic [BITS_DU-1:0] full_q [NB][NS1];
   logic [BITS_DU-1:0] rem_q [NR1];
   logic [WIDE-1:0]    rd_wide;
   logic [BITS_DE-1:0] s0_data, last_d, fwd_data_q;
   logic               oor_q, fwd_q;
   logic [BITS_O-1:0]  cnt_q, cnt_d, fcnt_q, fcnt_d;
   logic [LAT-1:0]     vpipe_q, vpipe_d;
   logic [BITS_P-1:0]  head_q, head_d, tail_q, tail_d;
   logic [BITS_DE-1:0] fifo_q [DEPTH_F];
   logic               unused_bits;

   assign wr_blk      = int'(32'(wr_addr) >> BITS_AU);
   assign rd_blk      = int'(32'(req_addr) >> BITS_AU);
   assign wr_off      = BITS_AU'(wr_addr);
   assign rd_off      = BITS_AU'(req_addr);
   assign wr_ok       = wr_en && (32'(wr_addr) < 32'(DEPTH_E));
   assign rd_in_range = 32'(req_addr) < 32'(DEPTH_E);

   // Full-width slices: one unit per block and slice.
   for (genvar gi = 0; gi < NB; gi++) begin : g_blk
      for (genvar gj = 0; gj < NS; gj++) begin : g_slice
         logic [BITS_DU-1:0] mem [UNIT_D] = init_unit(gi, 1, gj * BITS_DU, BITS_DU);
         logic [BITS_DU-1:0] rd_q;
         always_ff @(posedge clk) begin
            if (wr_ok && wr_blk == gi) mem[wr_off] <= wr_data[gj * BITS_DU +: BITS_DU];
            if (acc) rd_q <= mem[rd_off];
         end
         assign full_q[gi][gj] = rd_q;
      end
      if (NS == 0) begin : g_noslice
         assign full_q[gi][0] = '0;
      end
   end

   // Narrow top slices of NF neighbouring blocks share one unit, one lane each.
   for (genvar gi = 0; gi < NRB; gi++) begin : g_fold
      logic [BITS_DU-1:0] mem [UNIT_D] = init_unit(gi * NF, NF, NS * BITS_DU, RW);
      logic [BITS_DU-1:0] rd_q;
      always_ff @(posedge clk) begin
         for (int f = 0; f < NF; f++)
            if (wr_ok && wr_blk == gi * NF + f)
               mem[wr_off][f * RW +: RW] <= wr_data[NS * BITS_DU +: RW];
         if (acc) rd_q <= mem[rd_off];
      end
      assign rem_q[gi] = rd_q;
   end
   if (NRB == 0) begin : g_nofold
      assign rem_q[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (acc) begin
         rblk_q     <= rd_blk;
         oor_q      <= !rd_in_range;
         fwd_q      <= (RDW_MODE != 0) && wr_ok && (wr_addr == req_addr);
         fwd_data_q <= wr_data;
      end
   end

   always_comb begin
      rd_wide = '0;
      for (int b = 0; b < NB; b++) begin
         if (rblk_q == b) begin
            for (int s = 0; s < NS; s++) rd_wide[s * BITS_DU +: BITS_DU] = full_q[b][s];
            if (RW > 0) rd_wide[NS * BITS_DU +: RW1] = rem_q[b / NF][(b % NF) * RW1 +: RW1];
         end
      end
      s0_data = oor_q ? '0 : (fwd_q ? fwd_data_q : rd_wide[BITS_DE-1:0]);
   end

   if (LAT == 2) begin : g_oreg
      logic [BITS_DE-1:0] s1_q;
      always_ff @(posedge clk) s1_q <= s0_data;
      assign last_d = s1_q;
   end else begin : g_noreg
      assign last_d = s0_data;
   end

   // The last pipeline stage bypasses the FIFO when it is empty and the consumer is ready.
   always_comb begin
      req_ready  = run_q && (cnt_q < CNT_MAX);
      acc        = req_valid && req_ready;
      fifo_empty = (fcnt_q == '0);
      last_v     = vpipe_q[LAT-1];
      rsp_valid  = !fifo_empty || last_v;
      rsp_data   = '0;
      if (!fifo_empty)  rsp_data = fifo_q[head_q];
      else if (last_v)  rsp_data = last_d;
      hs      = rsp_valid && rsp_ready;
      pop     = !fifo_empty && rsp_ready;
      push    = last_v && !(fifo_empty && rsp_ready);
      cnt_d   = cnt_q + BITS_O'(acc) - BITS_O'(hs);
      fcnt_d  = fcnt_q + BITS_O'(push) - BITS_O'(pop);
      vpipe_d = LAT'({vpipe_q, acc});
      head_d  = head_q;
      tail_d  = tail_q;
      if (pop)  head_d = (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
      if (push) tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
   end

   assign outstanding = cnt_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run_q   <= 1'b0;
         cnt_q   <= '0;
         fcnt_q  <= '0;
         vpipe_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         run_q   <= 1'b1;
         cnt_q   <= cnt_d;
         fcnt_q  <= fcnt_d;
         vpipe_q <= vpipe_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[tail_q] <= last_d;
   end

   always_comb begin
      unused_bits = ^rd_wide;
      for (int r = 0; r < NR1; r++) unused_bits = unused_bits ^ (^rem_q[r]);
      for (int b = 0; b < NB; b++)
         for (int s = 0; s < NS1; s++) unused_bits = unused_bits ^ (^full_q[b][s]);
   end
endmodule

// File: tb/tb_ram_flex_stream.sv
// Bench for ram_flex_stream: two configurations driven in lockstep and compared
// every cycle against a queue-based model of the request/response contract.
module tb_ram_flex_stream;
   localparam int N  = 1000;
   localparam int W  = 20;
   localparam int AW = 10;

   typedef logic [W-1:0] init_t [N];
   function automatic init_t make_init();
      init_t a;
      for (int i = 0; i < N; i++) a[i] = W'(i * 3);
      return a;
   endfunction
   localparam init_t INIT_TAB = make_init();

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [W-1:0]  wr_data = '0;
   logic          req_valid = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic          rsp_ready = 1'b0;
   logic          req_ready [2];
   logic          rsp_valid [2];
   logic [W-1:0]  rsp_data [2];
   logic [1:0]    outstanding [2];

   always #5 clk = ~clk;

   ram_flex_stream #(.DEPTH(N), .BITS_D(W), .INIT_COUNT(N), .INIT_ARRAY(INIT_TAB),
                     .OUT_REG(0), .RDW_MODE(0)) dut0 (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .req_valid(req_valid), .req_ready(req_ready[0]), .req_addr(req_addr),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[0]),
      .outstanding(outstanding[0]));

   ram_flex_stream #(.DEPTH(N), .BITS_D(W), .INIT_COUNT(N), .INIT_ARRAY(INIT_TAB),
                     .OUT_REG(1), .RDW_MODE(1)) dut1 (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .req_valid(req_valid), .req_ready(req_ready[1]), .req_addr(req_addr),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[1]),
      .outstanding(outstanding[1]));

   typedef struct packed { logic [W-1:0] data; int ready; } rsp_t;
   rsp_t         expq [2][$];
   logic [W-1:0] mmem [N];
   int           lat [2] = '{1, 2};
   int           rdw [2] = '{0, 1};
   logic         exp_ready [2];
   logic         exp_valid [2];
   logic         run_m = 1'b0;
   int           edges = 0;
   int           checks = 0;
   int           errors = 0;

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, want);
      end
   endtask

   task automatic check_outputs();
      logic [W-1:0] d;
      for (int k = 0; k < 2; k++) begin
         exp_ready[k] = run_m && (expq[k].size() < lat[k] + 1);
         exp_valid[k] = (expq[k].size() > 0) && (expq[k][0].ready <= edges);
         d = exp_valid[k] ? expq[k][0].data : '0;
         chk("req_ready", k, 32'(req_ready[k]), 32'(exp_ready[k]));
         chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(exp_valid[k]));
         chk("rsp_data", k, 32'(rsp_data[k]), 32'(d));
         chk("outstanding", k, 32'(outstanding[k]), 32'(expq[k].size()));
         $display("t=%0t dut%0d rdy=%0b val=%0b data=%0h out=%0d", $time, k,
                  req_ready[k], rsp_valid[k], rsp_data[k], outstanding[k]);
      end
   endtask

   // Reference behaviour on a rising edge, from the values the bench is driving.
   task automatic model_edge();
      logic [W-1:0] d;
      edges++;
      for (int k = 0; k < 2; k++) begin
         if (exp_valid[k] && rsp_ready) void'(expq[k].pop_front());
         if (req_valid && exp_ready[k]) begin
            d = (int'(req_addr) < N) ? mmem[req_addr] : '0;
            if (rdw[k] == 1 && wr_en && wr_addr == req_addr && int'(wr_addr) < N) d = wr_data;
            expq[k].push_back('{data: d, ready: edges + lat[k] - 1});
         end
      end
      if (wr_en && int'(wr_addr) < N) mmem[wr_addr] = wr_data;
      run_m = rstn;
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic we, input int wa, input int wd, input logic rv, input int ra, input logic rr);
      wr_en     = we;
      wr_addr   = AW'(wa);
      wr_data   = W'(wd);
      req_valid = rv;
      req_addr  = AW'(ra);
      rsp_ready = rr;
   endtask

   task automatic idle(input int n, input logic rr);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 0, 0, 1'b0, 0, rr);
         cycle();
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) mmem[i] = W'(i * 3);
      exp_ready = '{1'b0, 1'b0};
      exp_valid = '{1'b0, 1'b0};

      // Held in reset, then released mid-cycle.
      idle(2, 1'b1);
      rstn = 1'b1;
      idle(2, 1'b1);

      // Stream every initial word, one request per cycle.
      for (int i = 0; i < N; i++) begin
         drive(1'b0, 0, 0, 1'b1, i, 1'b1);
         cycle();
      end
      idle(4, 1'b1);

      // Read-during-write on address 5, then a later read of it.
      drive(1'b1, 5, 'hABCDE, 1'b1, 5, 1'b1);
      cycle();
      idle(3, 1'b1);
      drive(1'b0, 0, 0, 1'b1, 5, 1'b1);
      cycle();
      idle(3, 1'b1);

      // Backpressure: requests held valid while the consumer stalls.
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 0, 0, 1'b1, 100 + i, 1'b0);
         cycle();
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 0, 0, 1'b1, 200 + i, 1'b1);
         cycle();
      end
      idle(4, 1'b1);

      // Out-of-range write and reads around the top of the address space.
      drive(1'b1, 1000, 1, 1'b0, 0, 1'b1);
      cycle();
      foreach (INIT_TAB[i]) begin
         if (i < 4) begin
            drive(1'b0, 0, 0, 1'b1, (i == 0) ? 1000 : (i == 1) ? 1023 : (i == 2) ? 999 : 1000 - 24, 1'b1);
            cycle();
         end
      end
      idle(3, 1'b1);

      // Write lands on the edge after the read was accepted.
      drive(1'b0, 0, 0, 1'b1, 7, 1'b1);
      cycle();
      drive(1'b1, 7, 'h12345, 1'b0, 0, 1'b1);
      cycle();
      idle(3, 1'b1);

      // Randomised traffic with frequent address collisions.
      for (int i = 0; i < 800; i++) begin
         drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1023),
               int'($urandom), ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1023),
               ($urandom_range(0, 9) < 6));
         cycle();
      end
      idle(5, 1'b1);

      // Two requests in flight, then a half-cycle reset pulse.
      drive(1'b1, 9, 'h5A5A5, 1'b1, 20, 1'b1);
      cycle();
      drive(1'b0, 0, 0, 1'b1, 21, 1'b1);
      cycle();
      drive(1'b0, 0, 0, 1'b0, 0, 1'b1);
      rstn = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
         chk("rst_outstanding", k, 32'(outstanding[k]), 32'd0);
         chk("rst_req_ready", k, 32'(req_ready[k]), 32'd0);
         chk("rst_rsp_data", k, 32'(rsp_data[k]), 32'd0);
         expq[k].delete();
         exp_ready[k] = 1'b0;
         exp_valid[k] = 1'b0;
      end
      run_m = 1'b0;
      @(negedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      model_edge();
      #1;
      idle(4, 1'b1);

      // Contents written before the reset survive it.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 0, 0, 1'b1, (i == 0) ? 9 : (i == 1) ? 5 : 7, 1'b1);
         cycle();
      end
      idle(4, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
